// File: rtl/pcm_soft_mute_seq_pkg.sv
// Shared types and helpers for the PCM soft-mute sequencer.
package pcm_mute_pkg;

    // Sequencer states; 3-bit encoding so the state register is easy to probe.
    typedef enum logic [2:0] {
        PLAY      = 3'd0,
        RAMP_DN   = 3'd1,
        HOLD      = 3'd2,
        MUTED_CLK = 3'd3,
        CLK_WAIT  = 3'd4,
        RAMP_UP   = 3'd5
    } mute_state_e;

    // Unity gain for a gain word with gw fraction bits.
    function automatic int gain_unity(input int gw);
        return 1 << gw;
    endfunction

    // Width of the shared frame counter; it must hold both HOLD_FRAMES-1
    // and CLK_SETTLE-1. Never narrower than one bit.
    function automatic int cnt_width(input int hold_frames, input int clk_settle);
        int m;
        m = (hold_frames > clk_settle) ? hold_frames : clk_settle;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pcm_soft_mute_seq_gain_mul.sv
// One-channel gain stage: signed sample times unsigned gain, shifted back by
// GW with truncation toward -inf. Unity gain bypasses the multiplier so the
// sample passes bit-exact.
module pcm_gain_mul
    import pcm_mute_pkg::*;
#(
    parameter int DW = 24,
    parameter int GW = 10
) (
    input  logic [DW-1:0] sample_i,
    input  logic [GW:0]   gain_i,
    output logic [DW-1:0] sample_o
);

    localparam int          PW    = DW + GW + 2;
    localparam int          GAW   = GW + 1;
    localparam logic [GW:0] UNITY = GAW'(gain_unity(GW));

    logic signed [PW-1:0] s_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod;

    // Sign-extend the sample, zero-extend the gain, multiply and scale back.
    always_comb begin
        s_ext    = {{(GW + 2){sample_i[DW-1]}}, sample_i};
        g_ext    = {{(DW + 1){1'b0}}, gain_i};
        prod     = s_ext * g_ext;
        sample_o = (gain_i == UNITY) ? sample_i : DW'(prod >>> GW);
    end

endmodule

// File: rtl/pcm_soft_mute_seq.sv
// Soft-mute sequencer: linear per-frame gain ramp on N_CH channels plus a
// clock-mute request that is only raised after data has been silent for
// HOLD_FRAMES frames, and dropped CLK_SETTLE frames before the ramp-up.
//
// Interface: frame_vld_i is a one-cycle strobe qualifying pcm_i; there is no
// backpressure. pcm_vld_o is that strobe delayed one cycle and qualifies
// pcm_o; pcm_o holds its value between strobes.
module pcm_soft_mute_seq
    import pcm_mute_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DW          = 24,
    parameter int GW          = 10,
    parameter int RAMP_STEP   = 8,
    parameter int HOLD_FRAMES = 1024,
    parameter int CLK_SETTLE  = 64
) (
    input  logic                 mck_i,
    input  logic                 nrst_i,
    input  logic                 mute_i,
    input  logic                 frame_vld_i,
    input  logic [N_CH*DW-1:0]   pcm_i,
    output logic [N_CH*DW-1:0]   pcm_o,
    output logic                 pcm_vld_o,
    output logic                 ndatmute_o,
    output logic                 nclkmute_o,
    output logic                 busy_o
);

    localparam int          GAW         = GW + 1;
    localparam int          CW          = cnt_width(HOLD_FRAMES, CLK_SETTLE);
    localparam logic [GW:0] UNITY_G     = GAW'(gain_unity(GW));
    localparam logic [GW:0] STEP_G      = GAW'(RAMP_STEP);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_FRAMES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(CLK_SETTLE - 1);

    logic mute_meta_q;
    logic mute_sync_q;

    mute_state_e state_q, state_d;
    logic [GW:0] gain_q, gain_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW:0] gain_dn;
    logic [GW:0] gain_up;

    logic ndat_q;
    logic nclk_q;
    logic busy_q;
    logic [N_CH*DW-1:0] mul_out;
    logic [N_CH*DW-1:0] pcm_q;
    logic               pcm_vld_q;

    // Two-flop synchroniser for the asynchronous mute request. It resets to
    // "muted" so the sequencer stays in MUTED_CLK until a real release is seen.
    always_ff @(posedge mck_i or negedge nrst_i) begin
        if (!nrst_i) begin
            mute_meta_q <= 1'b1;
            mute_sync_q <= 1'b1;
        end else begin
            mute_meta_q <= mute_i;
            mute_sync_q <= mute_meta_q;
        end
    end

    // Saturating one-step gain candidates used by the FSM.
    always_comb begin
        gain_dn = (gain_q <= STEP_G) ? '0 : (gain_q - STEP_G);
        gain_up = (gain_q >= (UNITY_G - STEP_G)) ? UNITY_G : (gain_q + STEP_G);
    end

    // Next-state, gain and counter logic. Ramp and hold transitions are
    // frame-gated and apply their gain step on the same frame; only the
    // MUTED_CLK <-> CLK_WAIT edges react to the synced request directly.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        cnt_d   = cnt_q;
        case (state_q)
            PLAY: begin
                if (frame_vld_i && mute_sync_q) begin
                    gain_d  = gain_dn;
                    cnt_d   = '0;
                    state_d = (gain_dn == '0) ? HOLD : RAMP_DN;
                end
            end
            RAMP_DN: begin
                if (frame_vld_i) begin
                    if (!mute_sync_q) begin
                        gain_d  = gain_up;
                        state_d = (gain_up == UNITY_G) ? PLAY : RAMP_UP;
                    end else begin
                        gain_d = gain_dn;
                        if (gain_dn == '0) begin
                            state_d = HOLD;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            HOLD: begin
                if (frame_vld_i) begin
                    if (!mute_sync_q) begin
                        gain_d  = gain_up;
                        state_d = (gain_up == UNITY_G) ? PLAY : RAMP_UP;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = MUTED_CLK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            MUTED_CLK: begin
                if (!mute_sync_q) begin
                    state_d = CLK_WAIT;
                    cnt_d   = '0;
                end
            end
            CLK_WAIT: begin
                if (mute_sync_q) begin
                    state_d = MUTED_CLK;
                end else if (frame_vld_i) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = RAMP_UP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RAMP_UP: begin
                if (frame_vld_i) begin
                    if (mute_sync_q) begin
                        gain_d  = gain_dn;
                        cnt_d   = '0;
                        state_d = (gain_dn == '0) ? HOLD : RAMP_DN;
                    end else begin
                        gain_d = gain_up;
                        if (gain_up == UNITY_G) begin
                            state_d = PLAY;
                        end
                    end
                end
            end
            default: begin
                state_d = MUTED_CLK;
                gain_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, gain, counter and status flags, all registered together so the
    // mute flags never glitch and always agree with the gain in use.
    always_ff @(posedge mck_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= MUTED_CLK;
            gain_q  <= '0;
            cnt_q   <= '0;
            ndat_q  <= 1'b0;
            nclk_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            cnt_q   <= cnt_d;
            ndat_q  <= (gain_d != '0);
            nclk_q  <= (state_d != MUTED_CLK);
            busy_q  <= (state_d == RAMP_DN) || (state_d == RAMP_UP) || (state_d == CLK_WAIT);
        end
    end

    // One gain stage per channel; all use the gain in force before this frame.
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        pcm_gain_mul #(
            .DW(DW),
            .GW(GW)
        ) u_mul (
            .sample_i(pcm_i[ch*DW +: DW]),
            .gain_i  (gain_q),
            .sample_o(mul_out[ch*DW +: DW])
        );
    end

    // Output register: capture the gained frame on the strobe, hold otherwise.
    always_ff @(posedge mck_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pcm_q     <= '0;
            pcm_vld_q <= 1'b0;
        end else begin
            pcm_vld_q <= frame_vld_i;
            if (frame_vld_i) begin
                pcm_q <= mul_out;
            end
        end
    end

    assign pcm_o      = pcm_q;
    assign pcm_vld_o  = pcm_vld_q;
    assign ndatmute_o = ndat_q;
    assign nclkmute_o = nclk_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_pcm_soft_mute_seq.sv
// Bench for pcm_soft_mute_seq: directed mute/unmute scenarios on a default
// instance plus a 6-channel single-step instance. Expected frames are queued
// when issued and popped by monitors whenever pcm_vld_o is seen.
module tb_pcm_soft_mute_seq;

    localparam int DW  = 24;
    localparam int GW  = 10;
    localparam int NC  = 2;
    localparam int W   = NC * DW;
    localparam int GW6 = 8;
    localparam int N6  = 6;
    localparam int W6  = N6 * DW;

    logic          clk = 1'b0;
    logic          nrst;
    logic          mute;
    logic          fv;
    logic [W-1:0]  pcm_i;
    logic [W-1:0]  pcm_o;
    logic          pcm_vld_o;
    logic          ndatmute_o;
    logic          nclkmute_o;
    logic          busy_o;

    logic          mute6;
    logic          fv6;
    logic [W6-1:0] pcm6_i;
    logic [W6-1:0] pcm6_o;
    logic          vld6;
    logic          ndat6;
    logic          nclk6;
    logic          busy6;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  exp_q[$];
    logic [W6-1:0] exp6_q[$];
    logic [W-1:0]  exp_pop;
    logic [W6-1:0] exp6_pop;
    logic [DW-1:0] samp6 [N6] = '{24'h123456, 24'hFEDCBA, 24'h7FFFFF,
                                  24'h800000, 24'h000001, 24'hFFFFFF};

    // Clock and DUTs
    always #5 clk = ~clk;

    pcm_soft_mute_seq dut (
        .mck_i      (clk),
        .nrst_i     (nrst),
        .mute_i     (mute),
        .frame_vld_i(fv),
        .pcm_i      (pcm_i),
        .pcm_o      (pcm_o),
        .pcm_vld_o  (pcm_vld_o),
        .ndatmute_o (ndatmute_o),
        .nclkmute_o (nclkmute_o),
        .busy_o     (busy_o)
    );

    pcm_soft_mute_seq #(
        .N_CH(N6),
        .DW(DW),
        .GW(GW6),
        .RAMP_STEP(256),
        .HOLD_FRAMES(1024),
        .CLK_SETTLE(64)
    ) dut6 (
        .mck_i      (clk),
        .nrst_i     (nrst),
        .mute_i     (mute6),
        .frame_vld_i(fv6),
        .pcm_i      (pcm6_i),
        .pcm_o      (pcm6_o),
        .pcm_vld_o  (vld6),
        .ndatmute_o (ndat6),
        .nclkmute_o (nclk6),
        .busy_o     (busy6)
    );

    // Reference gain arithmetic: signed sample times gain, floor shift.
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] s, input int g, input int gw);
        longint p;
        p = longint'(signed'(s)) * longint'(g);
        p = p >>> gw;
        return p[DW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Driver tasks: one frame every 8 clocks, mute changes given 4 clocks to sync.
    task automatic frame(input logic [DW-1:0] c0, input logic [DW-1:0] c1, input int g);
        exp_q.push_back({scale(c1, g, GW), scale(c0, g, GW)});
        @(negedge clk);
        pcm_i = {c1, c0};
        fv    = 1'b1;
        @(negedge clk);
        fv = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame6(input int g);
        logic [W6-1:0] e;
        logic [W6-1:0] v;
        for (int c = 0; c < N6; c++) begin
            e[c*DW +: DW] = scale(samp6[c], g, GW6);
            v[c*DW +: DW] = samp6[c];
        end
        exp6_q.push_back(e);
        @(negedge clk);
        pcm6_i = v;
        fv6    = 1'b1;
        @(negedge clk);
        fv6 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic set_mute(input logic v);
        @(negedge clk);
        mute = v;
        repeat (4) @(negedge clk);
    endtask

    // CLK_WAIT for 64 frames at gain 0, then 128 ramp frames to unity.
    task automatic unmute_seq();
        for (int k = 0; k < 64; k++) frame(24'h400000, 24'hFFFFFF, 0);
        check("settle_ndat", ndatmute_o, 1'b0);
        check("settle_busy", busy_o, 1'b1);
        for (int k = 0; k < 128; k++) begin
            frame(24'h400000, 24'hFFFFFF, 8 * k);
            if (k == 0) check("ramp_ndat_on", ndatmute_o, 1'b1);
        end
        check("play_busy", busy_o, 1'b0);
        check("play_ndat", ndatmute_o, 1'b1);
        check("play_nclk", nclkmute_o, 1'b1);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (nrst && pcm_vld_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pcm_unexpected: got %0h want none", pcm_o);
            end else begin
                exp_pop = exp_q.pop_front();
                if (pcm_o !== exp_pop) begin
                    bad++;
                    $display("FAIL pcm_o: got %0h want %0h", pcm_o, exp_pop);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (nrst && vld6) begin
            total++;
            if (exp6_q.size() == 0) begin
                bad++;
                $display("FAIL pcm6_unexpected: got %0h want none", pcm6_o);
            end else begin
                exp6_pop = exp6_q.pop_front();
                if (pcm6_o !== exp6_pop) begin
                    bad++;
                    $display("FAIL pcm6_o: got %0h want %0h", pcm6_o, exp6_pop);
                end
            end
        end
    end

    // Directed scenarios
    initial begin
        nrst   = 1'b0;
        mute   = 1'b0;
        fv     = 1'b0;
        pcm_i  = '0;
        mute6  = 1'b0;
        fv6    = 1'b0;
        pcm6_i = '0;
        repeat (3) @(negedge clk);
        check("rst_pcm_o", pcm_o, 0);
        check("rst_vld", pcm_vld_o, 1'b0);
        check("rst_ndat", ndatmute_o, 1'b0);
        check("rst_nclk", nclkmute_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst6_nclk", nclk6, 1'b0);

        // Power-up unmute
        nrst = 1'b1;
        @(posedge clk);
        #1 check("nclk_sync_lat", nclkmute_o, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("nclk_release", nclkmute_o, 1'b1);
        check("clkwait_busy", busy_o, 1'b1);
        unmute_seq();
        frame(24'h7FFFFF, 24'h800000, 1024);
        frame(24'h800000, 24'h7FFFFF, 1024);

        // Full mute: 128-frame ramp, 1024-frame hold, clock mute
        set_mute(1'b1);
        for (int k = 0; k < 128; k++) begin
            frame(24'h400000, 24'hC00000, 1024 - 8 * k);
            if (k == 126) check("dn_ndat_last", ndatmute_o, 1'b1);
        end
        check("dn_ndat_off", ndatmute_o, 1'b0);
        check("hold_busy", busy_o, 1'b0);
        for (int k = 0; k < 1024; k++) begin
            frame(24'h400000, 24'hC00000, 0);
            if (k == 1022) check("hold_nclk_on", nclkmute_o, 1'b1);
        end
        check("clk_muted", nclkmute_o, 1'b0);

        // Re-mute during CLK_WAIT
        set_mute(1'b0);
        check("clkwait_nclk", nclkmute_o, 1'b1);
        check("clkwait_busy2", busy_o, 1'b1);
        for (int k = 0; k < 10; k++) frame(24'h400000, 24'hC00000, 0);
        @(negedge clk);
        mute = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reassert_nclk", nclkmute_o, 1'b0);
        check("reassert_busy", busy_o, 1'b0);
        frame(24'h400000, 24'hC00000, 0);
        frame(24'h400000, 24'hC00000, 0);
        check("reassert_ndat", ndatmute_o, 1'b0);

        // Reset in the middle of RAMP_UP, then a clean restart
        set_mute(1'b0);
        for (int k = 0; k < 64; k++) frame(24'h400000, 24'hC00000, 0);
        for (int k = 0; k < 50; k++) frame(24'h400000, 24'hC00000, 8 * k);
        check("pre_rst_busy", busy_o, 1'b1);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("mid_rst_pcm_o", pcm_o, 0);
        check("mid_rst_vld", pcm_vld_o, 1'b0);
        check("mid_rst_ndat", ndatmute_o, 1'b0);
        check("mid_rst_nclk", nclkmute_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        check("restart_nclk", nclkmute_o, 1'b1);
        unmute_seq();

        // 40-frame mute blip: dips to 704, back to unity, clock untouched
        set_mute(1'b1);
        for (int k = 0; k < 40; k++) frame(24'h400000, 24'hC00000, 1024 - 8 * k);
        set_mute(1'b0);
        for (int k = 0; k < 40; k++) frame(24'h400000, 24'hC00000, 704 + 8 * k);
        check("blip_nclk", nclkmute_o, 1'b1);
        check("blip_busy", busy_o, 1'b0);
        check("blip_ndat", ndatmute_o, 1'b1);
        frame(24'h400000, 24'hC00000, 1024);

        // Release in HOLD after 500 frames: straight back to RAMP_UP
        set_mute(1'b1);
        for (int k = 0; k < 128; k++) frame(24'h400000, 24'hC00000, 1024 - 8 * k);
        for (int k = 0; k < 500; k++) frame(24'h400000, 24'hC00000, 0);
        check("hold500_busy", busy_o, 1'b0);
        check("hold500_nclk", nclkmute_o, 1'b1);
        set_mute(1'b0);
        frame(24'h400000, 24'hC00000, 0);
        check("holdrel_busy", busy_o, 1'b1);
        check("holdrel_nclk", nclkmute_o, 1'b1);
        check("holdrel_ndat", ndatmute_o, 1'b1);
        for (int k = 1; k < 128; k++) frame(24'h400000, 24'hC00000, 8 * k);
        check("holdrel_play_busy", busy_o, 1'b0);
        check("holdrel_play_ndat", ndatmute_o, 1'b1);

        // Six channels, single-step ramp
        for (int k = 0; k < 65; k++) frame6(0);
        check("ch6_play_ndat", ndat6, 1'b1);
        check("ch6_play_busy", busy6, 1'b0);
        frame6(256);
        @(negedge clk);
        mute6 = 1'b1;
        repeat (4) @(negedge clk);
        frame6(256);
        check("ch6_mute_ndat", ndat6, 1'b0);
        check("ch6_mute_busy", busy6, 1'b0);
        frame6(0);

        // Report
        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp6_q_drained", exp6_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
